// File: rtl/ddr4_rx_align_pkg.sv
// rtl/ddr4_rx_align_pkg.sv - shared types and constants for the DDR4 lane RX aligner
//
// Purpose: training FSM state encoding, default training word, delay-line
// direction codes and the tap-counter width helper.
// Ports: none (package).

package ddr4_rx_align_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETTLE,
        ST_CHECK,
        ST_SLIP,
        ST_EYE_CLR,
        ST_EYE_SAMPLE,
        ST_MOVE,
        ST_DONE,
        ST_ERROR
    } state_t;

    localparam logic [7:0] DEFAULT_TRAIN_PATTERN = 8'hB4;

    localparam logic DIR_INC = 1'b1;
    localparam logic DIR_DEC = 1'b0;

    // Width of a counter spanning 0..taps-1; never narrower than one bit.
    function automatic int tap_width(input int taps);
        return (taps <= 2) ? 1 : $clog2(taps);
    endfunction

endpackage

// File: rtl/ddr4_rx_pattern_checker.sv
// rtl/ddr4_rx_pattern_checker.sv - consecutive training-word match counter
//
// Purpose: compares each sampled word against the training pattern and counts
// consecutive matches; lock fires on the word that completes MATCH_COUNT.
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   clear         restart the run of matches
//   sample        the current word is to be judged this cycle
//   data[7:0]     deserialized word
//   match         data equals the pattern (combinational)
//   lock          this sampled word completes the required run (combinational)

module ddr4_rx_pattern_checker
    import ddr4_rx_align_pkg::*;
#(
    parameter logic [7:0] PATTERN     = DEFAULT_TRAIN_PATTERN,
    parameter int         MATCH_COUNT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       sample,
    input  logic [7:0] data,
    output logic       match,
    output logic       lock
);

    localparam logic [7:0] MATCH_LAST = 8'(MATCH_COUNT - 1);

    logic [7:0] run_q;

    assign match = (data == PATTERN);
    assign lock  = sample && match && (run_q == MATCH_LAST);

    // A mismatch breaks the run; a completed run also restarts so a later
    // retrain never inherits a stale count.
    always_ff @(posedge clk) begin
        if (rst || clear || (sample && (!match || lock))) begin
            run_q <= 8'd0;
        end else if (sample) begin
            run_q <= run_q + 8'd1;
        end
    end

endmodule

// File: rtl/ddr4_lane_rx_align.sv
// rtl/ddr4_lane_rx_align.sv - DDR4 lane read-leveling, bit-slip word alignment and eye centring
//
// Purpose: slips the 1:8 IOD deserializer until the training word locks, then
// steps the input delay line from the eye-monitor early/late flags until the
// sample point is centred, then forwards aligned read words.
// Ports:
//   FAB_CLK, RX_SYNC_RST          clock, synchronous active-high reset
//   TRAIN_START                   one-cycle (re)train request (IDLE/DONE/ERROR only)
//   RX_DATA[7:0]                  deserialized word, bit 0 earliest
//   EYE_MONITOR_EARLY/LATE        sticky eye flags
//   DELAY_LINE_OUT_OF_RANGE       delay-line limit flag
//   RX_BIT_SLIP                   slip pulse
//   DELAY_LINE_LOAD/MOVE          delay-line load / one-tap move pulses
//   DELAY_LINE_DIRECTION          1 = more delay
//   EYE_MONITOR_CLEAR_FLAGS       flag clear pulse
//   RD_EN, RD_DATA, RD_VALID      read window in, registered aligned word out
//   TRAIN_DONE, TRAIN_ERR         training status levels
//   SLIP_COUNT, TAP_COUNT         slips applied, net taps moved since load

module ddr4_lane_rx_align
    import ddr4_rx_align_pkg::*;
#(
    parameter logic [7:0] TRAIN_PATTERN = DEFAULT_TRAIN_PATTERN,
    parameter int         MATCH_COUNT   = 16,
    parameter int         SETTLE_CYCLES = 4,
    parameter int         DELAY_TAPS    = 128,
    localparam int        TAP_W         = tap_width(DELAY_TAPS)
) (
    input  logic             FAB_CLK,
    input  logic             RX_SYNC_RST,
    input  logic             TRAIN_START,
    input  logic [7:0]       RX_DATA,
    input  logic             EYE_MONITOR_EARLY,
    input  logic             EYE_MONITOR_LATE,
    input  logic             DELAY_LINE_OUT_OF_RANGE,
    output logic             RX_BIT_SLIP,
    output logic             DELAY_LINE_LOAD,
    output logic             DELAY_LINE_MOVE,
    output logic             DELAY_LINE_DIRECTION,
    output logic             EYE_MONITOR_CLEAR_FLAGS,
    input  logic             RD_EN,
    output logic [7:0]       RD_DATA,
    output logic             RD_VALID,
    output logic             TRAIN_DONE,
    output logic             TRAIN_ERR,
    output logic [2:0]       SLIP_COUNT,
    output logic [TAP_W-1:0] TAP_COUNT
);

    localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [TAP_W-1:0] TAP_MAX     = TAP_W'(DELAY_TAPS - 1);

    state_t           state_q, state_d;
    state_t           ret_q, ret_d;
    logic [3:0]       settle_q, settle_d;
    logic [2:0]       slip_q, slip_d;
    logic [TAP_W-1:0] tap_q, tap_d;
    logic             prev_valid_q, prev_valid_d;
    logic             prev_dir_q, prev_dir_d;
    logic             dir_q, dir_d;
    logic             load_q, load_d;
    logic             bslip_q, bslip_d;
    logic             move_q, move_d;
    logic             clr_q, clr_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [7:0]       rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;

    logic match, lock;
    logic want_inc, want_dec, want_dir;

    ddr4_rx_pattern_checker #(
        .PATTERN     (TRAIN_PATTERN),
        .MATCH_COUNT (MATCH_COUNT)
    ) u_checker (
        .clk    (FAB_CLK),
        .rst    (RX_SYNC_RST),
        .clear  ((state_q == ST_LOAD) || (state_q == ST_SLIP)),
        .sample (state_q == ST_CHECK),
        .data   (RX_DATA),
        .match  (match),
        .lock   (lock)
    );

    // Both flags set is as inconclusive as neither: stop where we are.
    assign want_inc = EYE_MONITOR_EARLY && !EYE_MONITOR_LATE;
    assign want_dec = EYE_MONITOR_LATE && !EYE_MONITOR_EARLY;
    assign want_dir = want_inc ? DIR_INC : DIR_DEC;

    always_comb begin
        state_d      = state_q;
        ret_d        = ret_q;
        settle_d     = settle_q;
        slip_d       = slip_q;
        tap_d        = tap_q;
        prev_valid_d = prev_valid_q;
        prev_dir_d   = prev_dir_q;
        dir_d        = dir_q;
        rd_data_d    = rd_data_q;

        unique case (state_q)
            ST_IDLE: begin
                if (TRAIN_START) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                state_d  = ST_SETTLE;
                ret_d    = ST_CHECK;
                settle_d = 4'd0;
            end
            ST_SETTLE: begin
                if (DELAY_LINE_OUT_OF_RANGE)      state_d = ST_ERROR;
                else if (settle_q == SETTLE_LAST) state_d = ret_q;
                else                              settle_d = settle_q + 4'd1;
            end
            ST_CHECK: begin
                if (lock)        state_d = ST_EYE_CLR;
                else if (!match) state_d = ST_SLIP;
            end
            ST_SLIP: begin
                // Seven slips cover every rotation of an 8-bit word.
                if (slip_q == 3'd7) begin
                    state_d = ST_ERROR;
                end else begin
                    slip_d   = slip_q + 3'd1;
                    state_d  = ST_SETTLE;
                    ret_d    = ST_CHECK;
                    settle_d = 4'd0;
                end
            end
            ST_EYE_CLR: begin
                state_d  = ST_SETTLE;
                ret_d    = ST_EYE_SAMPLE;
                settle_d = 4'd0;
            end
            ST_EYE_SAMPLE: begin
                if (DELAY_LINE_OUT_OF_RANGE) begin
                    state_d = ST_ERROR;
                end else if (want_inc == want_dec) begin
                    state_d = ST_DONE;
                end else if (prev_valid_q && (prev_dir_q != want_dir)) begin
                    // Flag flipped sides after a step: we just crossed the centre.
                    state_d = ST_DONE;
                end else if ((want_inc && tap_q == TAP_MAX) ||
                             (want_dec && tap_q == '0)) begin
                    state_d = ST_ERROR;
                end else begin
                    state_d = ST_MOVE;
                    dir_d   = want_dir;
                end
            end
            ST_MOVE: begin
                tap_d        = (dir_q == DIR_INC) ? tap_q + TAP_W'(1) : tap_q - TAP_W'(1);
                prev_valid_d = 1'b1;
                prev_dir_d   = dir_q;
                if (DELAY_LINE_OUT_OF_RANGE) begin
                    state_d = ST_ERROR;
                end else begin
                    state_d  = ST_SETTLE;
                    ret_d    = ST_EYE_CLR;
                    settle_d = 4'd0;
                end
            end
            ST_DONE: begin
                rd_data_d = RX_DATA;
                if (TRAIN_START) state_d = ST_LOAD;
            end
            ST_ERROR: begin
                if (TRAIN_START) state_d = ST_LOAD;
            end
            default: state_d = ST_IDLE;
        endcase

        // Clear on entry so the LOAD cycle already reports zero counts.
        if (state_d == ST_LOAD) begin
            slip_d       = 3'd0;
            tap_d        = '0;
            prev_valid_d = 1'b0;
        end

        // Pulses and levels are decoded from the next state and registered,
        // so each is glitch-free and aligned with its state's single cycle.
        load_d     = (state_d == ST_LOAD);
        bslip_d    = (state_d == ST_SLIP) && (slip_q != 3'd7);
        move_d     = (state_d == ST_MOVE);
        clr_d      = (state_d == ST_EYE_CLR);
        done_d     = (state_d == ST_DONE);
        err_d      = (state_d == ST_ERROR);
        rd_valid_d = (state_q == ST_DONE) && (state_d == ST_DONE) && RD_EN;
    end

    always_ff @(posedge FAB_CLK) begin
        if (RX_SYNC_RST) begin
            state_q      <= ST_IDLE;
            ret_q        <= ST_IDLE;
            settle_q     <= 4'd0;
            slip_q       <= 3'd0;
            tap_q        <= '0;
            prev_valid_q <= 1'b0;
            prev_dir_q   <= 1'b0;
            dir_q        <= 1'b0;
            load_q       <= 1'b0;
            bslip_q      <= 1'b0;
            move_q       <= 1'b0;
            clr_q        <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            rd_data_q    <= 8'd0;
            rd_valid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            ret_q        <= ret_d;
            settle_q     <= settle_d;
            slip_q       <= slip_d;
            tap_q        <= tap_d;
            prev_valid_q <= prev_valid_d;
            prev_dir_q   <= prev_dir_d;
            dir_q        <= dir_d;
            load_q       <= load_d;
            bslip_q      <= bslip_d;
            move_q       <= move_d;
            clr_q        <= clr_d;
            done_q       <= done_d;
            err_q        <= err_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
        end
    end

    assign RX_BIT_SLIP             = bslip_q;
    assign DELAY_LINE_LOAD         = load_q;
    assign DELAY_LINE_MOVE         = move_q;
    assign DELAY_LINE_DIRECTION    = dir_q;
    assign EYE_MONITOR_CLEAR_FLAGS = clr_q;
    assign RD_DATA                 = rd_data_q;
    assign RD_VALID                = rd_valid_q;
    assign TRAIN_DONE              = done_q;
    assign TRAIN_ERR               = err_q;
    assign SLIP_COUNT              = slip_q;
    assign TAP_COUNT               = tap_q;

endmodule

// File: tb/tb_ddr4_lane_rx_align.sv
// tb/tb_ddr4_lane_rx_align.sv - self-checking bench for ddr4_lane_rx_align

module tb_ddr4_lane_rx_align;

    localparam logic [7:0] PAT = 8'hB4;

    logic       clk = 1'b0;
    logic       rst, start, early, late, oor, rd_en;
    logic [7:0] rx;

    logic       bslip, load, move, dir, clr, rd_valid, done, err;
    logic [7:0] rd_data;
    logic [2:0] slip_cnt;
    logic [6:0] tap_cnt;

    logic       d8_bslip, d8_load, d8_move, d8_dir, d8_clr, d8_rd_valid, d8_done, d8_err;
    logic [7:0] d8_rd_data;
    logic [2:0] d8_slip_cnt;
    logic [2:0] d8_tap_cnt;

    always #5 clk = ~clk;

    ddr4_lane_rx_align dut (
        .FAB_CLK(clk), .RX_SYNC_RST(rst), .TRAIN_START(start), .RX_DATA(rx),
        .EYE_MONITOR_EARLY(early), .EYE_MONITOR_LATE(late), .DELAY_LINE_OUT_OF_RANGE(oor),
        .RX_BIT_SLIP(bslip), .DELAY_LINE_LOAD(load), .DELAY_LINE_MOVE(move),
        .DELAY_LINE_DIRECTION(dir), .EYE_MONITOR_CLEAR_FLAGS(clr), .RD_EN(rd_en),
        .RD_DATA(rd_data), .RD_VALID(rd_valid), .TRAIN_DONE(done), .TRAIN_ERR(err),
        .SLIP_COUNT(slip_cnt), .TAP_COUNT(tap_cnt)
    );

    ddr4_lane_rx_align #(.DELAY_TAPS(8)) dut8 (
        .FAB_CLK(clk), .RX_SYNC_RST(rst), .TRAIN_START(start), .RX_DATA(rx),
        .EYE_MONITOR_EARLY(early), .EYE_MONITOR_LATE(late), .DELAY_LINE_OUT_OF_RANGE(oor),
        .RX_BIT_SLIP(d8_bslip), .DELAY_LINE_LOAD(d8_load), .DELAY_LINE_MOVE(d8_move),
        .DELAY_LINE_DIRECTION(d8_dir), .EYE_MONITOR_CLEAR_FLAGS(d8_clr), .RD_EN(rd_en),
        .RD_DATA(d8_rd_data), .RD_VALID(d8_rd_valid), .TRAIN_DONE(d8_done), .TRAIN_ERR(d8_err),
        .SLIP_COUNT(d8_slip_cnt), .TAP_COUNT(d8_tap_cnt)
    );

    int checks = 0;
    int failures = 0;

    // IOD / eye-monitor model state
    int iod_slips = 0, offset = 0, iod_moves = 0;
    int slips_seen = 0, moves_seen = 0, inc_moves = 0, load_seen = 0, d8_moves = 0;
    int data_mode = 0;   // 0 rotated pattern, 1 never matches, 2 random, 3 manual
    int eye_mode = 0;    // 0 no flags, 1 early for eye_n samples then late, 2 early forever
    int eye_n = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int k);
        logic [7:0] r;
        r = v;
        for (int i = 0; i < k; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    task automatic drive_inputs();
        case (data_mode)
            0: rx = rotl8(PAT, ((offset - iod_slips) % 8 + 8) % 8);
            1: rx = 8'h00;
            2: rx = 8'($urandom);
            default: ;
        endcase
        case (eye_mode)
            1: begin early = (iod_moves < eye_n); late = !early; end
            2: begin early = 1'b1; late = 1'b0; end
            default: begin early = 1'b0; late = 1'b0; end
        endcase
        if (data_mode != 3) rd_en = 1'($urandom_range(0, 1));
    endtask

    // One clock: observe this cycle's pulses at negedge, advance, drive new inputs.
    task automatic tick();
        @(negedge clk);
        if (load) begin iod_moves = 0; load_seen++; end
        if (bslip) begin iod_slips++; slips_seen++; end
        if (move) begin
            moves_seen++;
            if (dir) begin inc_moves++; iod_moves++; end
            else iod_moves--;
        end
        if (d8_move) d8_moves++;
        @(posedge clk);
        #1;
        drive_inputs();
    endtask

    task automatic start_train();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_end(input int budget);
        int n;
        n = 0;
        while (!(done || err) && n < budget) begin
            tick();
            n++;
        end
        check("train_finished", done | err, 1);
    endtask

    // Cycle-by-cycle compare against counts derived from observed pulses.
    int         m_slips = 0, m_taps = 0;
    logic [3:0] p_pulses = '0;
    logic       p_move = 0, p_dir = 0, p_done = 0, p_rden = 0;
    logic [7:0] p_rx = '0;

    always @(negedge clk) begin
        if (rst) begin
            m_slips = 0; m_taps = 0; p_pulses = '0;
            p_move = 0; p_dir = 0; p_done = 0; p_rden = 0; p_rx = '0;
        end else begin
            if (load) begin m_slips = 0; m_taps = 0; end
            check("pulse_exclusive", $countones({load, bslip, move, clr}) <= 1, 1);
            check("pulse_width", {load, bslip, move, clr} & p_pulses, 0);
            check("slip_count", slip_cnt, m_slips & 7);
            check("tap_count", tap_cnt, m_taps & 127);
            check("done_err_exclusive", done & err, 0);
            if (p_move) check("direction_held", dir, p_dir);
            if (done && p_done) begin
                check("rd_valid", rd_valid, p_rden);
                check("rd_data", rd_data, p_rx);
            end else begin
                check("rd_valid_outside_done", rd_valid, 0);
            end
            if (bslip) m_slips++;
            if (move) m_taps += dir ? 1 : -1;
            p_pulses = {load, bslip, move, clr};
            p_move = move; p_dir = dir; p_done = done; p_rden = rd_en; p_rx = rx;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, l0, s0, m0, i0, d0;
        rst = 1'b1; start = 1'b0; early = 1'b0; late = 1'b0; oor = 1'b0; rd_en = 1'b0; rx = PAT;
        @(posedge clk);
        #1;
        tick();
        tick();
        check("reset_outputs",
              {bslip, load, move, dir, clr, rd_data, rd_valid, done, err, slip_cnt, tap_cnt}, 0);
        rst = 1'b0;
        tick();

        // No slip needed; TRAIN_START during CHECK must be ignored.
        l0 = load_seen; s0 = slips_seen;
        start_train();
        n = 0;
        while (!(done || err) && n < 200) begin
            if (n == 12) start = 1'b1;
            tick();
            start = 1'b0;
            n++;
        end
        check("lock_time_lo", n >= 26, 1);
        check("lock_time_hi", n <= 28, 1);
        check("t1_done", done, 1);
        check("t1_loads", load_seen - l0, 1);
        check("t1_slips", slips_seen - s0, 0);
        check("t1_slip_count", slip_cnt, 0);
        check("t1_tap_count", tap_cnt, 0);

        // Data path literals, then random traffic checked by the compare process.
        data_mode = 3;
        rx = 8'h11; rd_en = 1'b1;
        tick();
        rx = 8'h22; rd_en = 1'b0;
        check("dp_valid_1", rd_valid, 1);
        check("dp_data_1", rd_data, 8'h11);
        tick();
        rx = 8'h33; rd_en = 1'b1;
        check("dp_valid_2", rd_valid, 0);
        check("dp_data_2", rd_data, 8'h22);
        tick();
        rd_en = 1'b0;
        check("dp_valid_3", rd_valid, 1);
        check("dp_data_3", rd_data, 8'h33);
        data_mode = 2;
        for (int k = 0; k < 30; k++) tick();

        // Eye centring: early for five samples, then late. Restart from DONE.
        data_mode = 0; eye_mode = 1; eye_n = 5;
        drive_inputs();
        m0 = moves_seen; i0 = inc_moves;
        start_train();
        check("restart_load", load, 1);
        check("restart_done_low", done, 0);
        wait_end(600);
        check("eye_done", done, 1);
        check("eye_tap_count", tap_cnt, 5);
        check("eye_moves", moves_seen - m0, 5);
        check("eye_inc_moves", inc_moves - i0, 5);

        // Lane three bits off.
        iod_slips = 0; offset = 3; eye_mode = 0;
        drive_inputs();
        s0 = slips_seen;
        start_train();
        wait_end(600);
        check("slip3_done", done, 1);
        check("slip3_pulses", slips_seen - s0, 3);
        check("slip3_count", slip_cnt, 3);

        // Random offsets and eye positions.
        for (int it = 0; it < 4; it++) begin
            iod_slips = 0;
            offset = $urandom_range(0, 7);
            eye_mode = 1;
            eye_n = $urandom_range(1, 6);
            drive_inputs();
            start_train();
            wait_end(800);
            check("rand_done", done, 1);
            check("rand_slip_count", slip_cnt, offset);
            check("rand_tap_count", tap_cnt, eye_n);
        end

        // Pattern never matches.
        data_mode = 1; eye_mode = 0;
        drive_inputs();
        s0 = slips_seen;
        start_train();
        wait_end(600);
        check("nomatch_err", err, 1);
        check("nomatch_slip_count", slip_cnt, 7);
        check("nomatch_pulses", slips_seen - s0, 7);

        // Out-of-range during SETTLE; restart from ERROR.
        data_mode = 0; iod_slips = 0; offset = 0;
        drive_inputs();
        start_train();
        check("oor_load", load, 1);
        tick();
        oor = 1'b1;
        check("oor_err_before", err, 0);
        tick();
        check("oor_err_after", err, 1);
        oor = 1'b0;

        // Permanent EARLY: 8-tap lane hits its limit, 128-tap lane hits its own.
        eye_mode = 2;
        drive_inputs();
        d0 = d8_moves;
        start_train();
        n = 0;
        while (!d8_err && n < 300) begin
            tick();
            n++;
        end
        check("tap8_err", d8_err, 1);
        check("tap8_done", d8_done, 0);
        check("tap8_count", d8_tap_cnt, 7);
        check("tap8_moves", d8_moves - d0, 7);
        wait_end(2500);
        check("tap128_err", err, 1);
        check("tap128_count", tap_cnt, 127);

        // Reset in the middle of a MOVE pulse, then retrain.
        eye_mode = 1; eye_n = 3;
        drive_inputs();
        start_train();
        n = 0;
        while (!move && n < 200) begin
            tick();
            n++;
        end
        check("move_seen", move, 1);
        rst = 1'b1;
        tick();
        check("midmove_reset_outputs",
              {bslip, load, move, dir, clr, rd_data, rd_valid, done, err, slip_cnt, tap_cnt}, 0);
        tick();
        rst = 1'b0;
        tick();
        start_train();
        wait_end(600);
        check("retrain_done", done, 1);
        check("retrain_tap_count", tap_cnt, 3);
        check("retrain_slip_count", slip_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
